// File: rtl/bcd_conv_arbiter_if.sv
// Bus bundle between the numeric-field producers, the arbiter and the shared
// binary-to-BCD/ASCII converter. The arbiter uses the slave modport; the
// requesters and the converter together sit on the master side.
interface bcd_conv_arbiter_if #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ASCII_WIDTH = 80
);
    // Handshake: a requester raises req_i (a level) with its operand on data_i
    // and holds both until ack_o pulses for one cycle; later done_o pulses once
    // for that requester with ascii_o/width_o/err_o valid. The converter gets a
    // one-cycle conv_start_o with conv_data_o and answers with one conv_done_i
    // cycle carrying conv_ascii_i/conv_width_i.
    logic [NUM_REQ-1:0]            req_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
    logic [NUM_REQ-1:0]            ack_o;
    logic [NUM_REQ-1:0]            done_o;
    logic                          err_o;
    logic [ASCII_WIDTH-1:0]        ascii_o;
    logic [3:0]                    width_o;
    logic                          busy_o;
    logic                          conv_start_o;
    logic [DATA_WIDTH-1:0]         conv_data_o;
    logic                          conv_done_i;
    logic [ASCII_WIDTH-1:0]        conv_ascii_i;
    logic [3:0]                    conv_width_i;

    modport slave (
        input  req_i, data_i, conv_done_i, conv_ascii_i, conv_width_i,
        output ack_o, done_o, err_o, ascii_o, width_o, busy_o,
               conv_start_o, conv_data_o
    );

    modport master (
        output req_i, data_i, conv_done_i, conv_ascii_i, conv_width_i,
        input  ack_o, done_o, err_o, ascii_o, width_o, busy_o,
               conv_start_o, conv_data_o
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one binary-to-BCD/ASCII converter between the
// FIX numeric-field producers, with a completion watchdog.
module bcd_conv_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int ASCII_WIDTH = 80,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk,
    input  logic                rst,
    bcd_conv_arbiter_if.slave   bus,
    output logic [1:0]          dbg_state_o
);
    localparam int GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int MAX_DIGITS = ASCII_WIDTH / 8;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          last_q;
    logic [CW-1:0]          cnt_q;
    logic [NUM_REQ-1:0]     ack_q;
    logic [NUM_REQ-1:0]     done_q;
    logic                   err_q;
    logic                   busy_q;
    logic                   start_q;
    logic [ASCII_WIDTH-1:0] ascii_q;
    logic [3:0]             width_q;
    logic [DATA_WIDTH-1:0]  cdata_q;

    logic [GW-1:0]          pick_d;
    logic                   pick_vld_d;
    logic [DATA_WIDTH-1:0]  pick_data_d;

    // Requester index 'off' positions after the last grant, wrapping around.
    function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] last, input int off);
        return GW'((int'(last) + off) % NUM_REQ);
    endfunction

    // Round-robin pick: walk offsets from far to near so the nearest active
    // requester after last_q is the one that sticks.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_d     = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.req_i[rr_idx(last_q, i)]) begin
                pick_vld_d = 1'b1;
                pick_d     = rr_idx(last_q, i);
            end
        end
    end

    // Operand slice of the requester about to be granted.
    always_comb begin
        pick_data_d = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_d == GW'(k)) begin
                pick_data_d = bus.data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Conversion sequencer; all outputs are registered here, pulses default low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            cnt_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            ascii_q <= '0;
            width_q <= '0;
            cdata_q <= '0;
        end else begin
            ack_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_q <= pick_d;
                        last_q  <= pick_d;
                        cdata_q <= pick_data_d;
                        ack_q   <= ONE << pick_d;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // A done arriving on the timeout cycle still counts as a result.
                    if (bus.conv_done_i) begin
                        ascii_q <= bus.conv_ascii_i;
                        width_q <= bus.conv_width_i;
                        err_q   <= (bus.conv_width_i == 4'd0) ||
                                   (bus.conv_width_i > 4'(MAX_DIGITS));
                        done_q  <= ONE << grant_q;
                        state_q <= DONE;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        ascii_q <= '0;
                        width_q <= '0;
                        err_q   <= 1'b1;
                        done_q  <= ONE << grant_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack_o        = ack_q;
    assign bus.done_o       = done_q;
    assign bus.err_o        = err_q;
    assign bus.ascii_o      = ascii_q;
    assign bus.width_o      = width_q;
    assign bus.busy_o       = busy_q;
    assign bus.conv_start_o = start_q;
    assign bus.conv_data_o  = cdata_q;
    assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: drives the requesters, models the converter and
// checks grants, timing and results against a round-robin reference.
module tb_bcd_conv_arbiter;
    localparam int NR = 3;
    localparam int DW = 32;
    localparam int AW = 80;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [1:0] dbg_state;
    int cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    bcd_conv_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ASCII_WIDTH(AW)) bus ();

    bcd_conv_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ASCII_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
    );

    // Clock and cycle counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Requester drive.
    logic [NR-1:0]    req_r = '0;
    logic [NR*DW-1:0] data_r = '0;
    assign bus.req_i  = req_r;
    assign bus.data_i = data_r;

    // Converter model: answers conv_start_o after conv_lat cycles.
    int          conv_lat = 5;
    bit          conv_hang = 1'b0;
    bit          conv_bad = 1'b0;
    logic        stray_done = 1'b0;
    logic        model_done = 1'b0;
    logic [AW-1:0] model_ascii = '0;
    logic [3:0]  model_width = '0;
    assign bus.conv_done_i  = model_done | stray_done;
    assign bus.conv_ascii_i = model_ascii;
    assign bus.conv_width_i = model_width;

    initial begin : conv_model
        bit pending = 1'b0;
        int left = 0;
        logic [DW-1:0] held = '0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!rst) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    left--;
                    if (left == 0) begin
                        logic [DW-1:0] v;
                        int w;
                        v = held;
                        w = 0;
                        model_ascii = '0;
                        do begin
                            model_ascii[8*w +: 8] = 8'h30 + 8'(v % 10);
                            v = v / 10;
                            w++;
                        end while (v != 0);
                        model_width = conv_bad ? 4'd11 : 4'(w);
                        model_done = 1'b1;
                        pending = 1'b0;
                    end
                end
                if (bus.conv_start_o && !conv_hang) begin
                    pending = 1'b1;
                    left = conv_lat;
                    held = bus.conv_data_o;
                end
            end
        end
    end

    // Reference model: round-robin pointer and decimal rendering.
    int rr_last = NR - 1;
    logic [1:0] exp_q[$];

    function automatic int next_grant(input logic [NR-1:0] pend, input int last);
        for (int off = 1; off <= NR; off++) begin
            if (pend[(last + off) % NR]) return (last + off) % NR;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] ref_ascii(input logic [DW-1:0] v);
        string s;
        logic [AW-1:0] r;
        s = $sformatf("%0d", v);
        r = '0;
        for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[s.len()-1-i];
        return r;
    endfunction

    function automatic int ref_width(input logic [DW-1:0] v);
        string s;
        s = $sformatf("%0d", v);
        return s.len();
    endfunction

    function automatic int oh_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v == (NR'(1) << i)) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] op(input int k);
        logic [NR*DW-1:0] d;
        d = data_r;
        return d[k*DW +: DW];
    endfunction

    // Observation log of one run.
    int ack_idx_q[$], ack_cyc_q[$], done_idx_q[$], done_cyc_q[$];
    logic [DW-1:0] start_data_q[$];
    logic [AW-1:0] done_ascii_q[$];
    logic [3:0] done_w_q[$];
    logic done_err_q[$];
    int ack_start_err;
    int req_cyc;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_r = '0;
        tick(2);
        rst = 1'b1;
        rr_last = NR - 1;
        tick(2);
    endtask

    // Raise 'mask', run until n_done done pulses or budget expires.
    task automatic run(input logic [NR-1:0] mask, input bit cont, input int n_done,
                       input int budget, output bit timed_out);
        int got;
        ack_idx_q.delete(); ack_cyc_q.delete(); done_idx_q.delete(); done_cyc_q.delete();
        start_data_q.delete(); done_ascii_q.delete(); done_w_q.delete(); done_err_q.delete();
        ack_start_err = 0;
        got = 0;
        req_cyc = cyc;
        req_r = mask;
        for (int c = 0; c < budget && got < n_done; c++) begin
            @(negedge clk);
            if ((bus.ack_o != '0) !== bus.conv_start_o) ack_start_err++;
            if (bus.ack_o != '0) begin
                ack_idx_q.push_back(oh_idx(bus.ack_o));
                ack_cyc_q.push_back(cyc);
                start_data_q.push_back(bus.conv_data_o);
                if (!cont) req_r = req_r & ~bus.ack_o;
            end
            if (bus.done_o != '0) begin
                done_idx_q.push_back(oh_idx(bus.done_o));
                done_cyc_q.push_back(cyc);
                done_ascii_q.push_back(bus.ascii_o);
                done_w_q.push_back(bus.width_o);
                done_err_q.push_back(bus.err_o);
                got++;
            end
        end
        req_r = '0;
        timed_out = (got < n_done);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(2);
        vectors++; if (bus.ack_o !== '0) begin miscompares++; $display("FAIL reset_ack: got %0h expected 0", bus.ack_o); end
        vectors++; if (bus.done_o !== '0) begin miscompares++; $display("FAIL reset_done: got %0h expected 0", bus.done_o); end
        vectors++; if (bus.err_o !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0h expected 0", bus.err_o); end
        vectors++; if (bus.ascii_o !== '0) begin miscompares++; $display("FAIL reset_ascii: got %0h expected 0", bus.ascii_o); end
        vectors++; if (bus.width_o !== '0) begin miscompares++; $display("FAIL reset_width: got %0h expected 0", bus.width_o); end
        vectors++; if (bus.busy_o !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0h expected 0", bus.busy_o); end
        vectors++; if (bus.conv_start_o !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %0h expected 0", bus.conv_start_o); end
        vectors++; if (bus.conv_data_o !== '0) begin miscompares++; $display("FAIL reset_cdata: got %0h expected 0", bus.conv_data_o); end
        rst = 1'b1;
        rr_last = NR - 1;
        tick(2);
    endtask

    task automatic test_single();
        bit to;
        data_r = '0;
        data_r[0*DW +: DW] = 32'd137;
        conv_lat = 5;
        tick(2);
        run(3'b001, 1'b0, 1, 40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL single_timeout: got no done expected done_o[0]"); end
        else begin
            vectors++; if (ack_idx_q[0] !== 0) begin miscompares++; $display("FAIL single_ack_idx: got %0d expected 0", ack_idx_q[0]); end
            vectors++; if (ack_cyc_q[0] - req_cyc !== 1) begin miscompares++; $display("FAIL single_ack_lat: got %0d expected 1", ack_cyc_q[0] - req_cyc); end
            vectors++; if (done_idx_q[0] !== 0) begin miscompares++; $display("FAIL single_done_idx: got %0d expected 0", done_idx_q[0]); end
            vectors++; if (done_cyc_q[0] - ack_cyc_q[0] !== 6) begin miscompares++; $display("FAIL single_done_lat: got %0d expected 6", done_cyc_q[0] - ack_cyc_q[0]); end
            vectors++; if (done_w_q[0] !== 4'd3) begin miscompares++; $display("FAIL single_width: got %0d expected 3", done_w_q[0]); end
            vectors++; if (done_err_q[0] !== 1'b0) begin miscompares++; $display("FAIL single_err: got %0d expected 0", done_err_q[0]); end
            vectors++; if (done_ascii_q[0] !== ref_ascii(32'd137)) begin miscompares++; $display("FAIL single_ascii: got %0h expected %0h", done_ascii_q[0], ref_ascii(32'd137)); end
            vectors++; if (start_data_q[0] !== 32'd137) begin miscompares++; $display("FAIL single_cdata: got %0d expected 137", start_data_q[0]); end
            rr_last = 0;
        end
    endtask

    // Compare a logged multi-grant run against exp_q.
    task automatic check_sequence(input string name, input int lat);
        vectors++; if (ack_start_err !== 0) begin miscompares++; $display("FAIL %s_ack_vs_start: got %0d disagreements expected 0", name, ack_start_err); end
        vectors++; if (done_idx_q.size() !== exp_q.size()) begin miscompares++; $display("FAIL %s_count: got %0d expected %0d", name, done_idx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < done_idx_q.size() && i < ack_idx_q.size(); i++) begin
            vectors++; if (ack_idx_q[i] !== int'(exp_q[i])) begin miscompares++; $display("FAIL %s_grant[%0d]: got %0d expected %0d", name, i, ack_idx_q[i], exp_q[i]); end
            vectors++; if (done_idx_q[i] !== int'(exp_q[i])) begin miscompares++; $display("FAIL %s_done[%0d]: got %0d expected %0d", name, i, done_idx_q[i], exp_q[i]); end
            vectors++; if (start_data_q[i] !== op(int'(exp_q[i]))) begin miscompares++; $display("FAIL %s_cdata[%0d]: got %0d expected %0d", name, i, start_data_q[i], op(int'(exp_q[i]))); end
            vectors++; if (done_ascii_q[i] !== ref_ascii(op(int'(exp_q[i])))) begin miscompares++; $display("FAIL %s_ascii[%0d]: got %0h expected %0h", name, i, done_ascii_q[i], ref_ascii(op(int'(exp_q[i])))); end
            vectors++; if (int'(done_w_q[i]) !== ref_width(op(int'(exp_q[i])))) begin miscompares++; $display("FAIL %s_width[%0d]: got %0d expected %0d", name, i, done_w_q[i], ref_width(op(int'(exp_q[i])))); end
            vectors++; if (done_err_q[i] !== 1'b0) begin miscompares++; $display("FAIL %s_err[%0d]: got %0d expected 0", name, i, done_err_q[i]); end
            vectors++; if (done_cyc_q[i] - ack_cyc_q[i] !== lat + 1) begin miscompares++; $display("FAIL %s_lat[%0d]: got %0d expected %0d", name, i, done_cyc_q[i] - ack_cyc_q[i], lat + 1); end
            if (i + 1 < ack_cyc_q.size()) begin
                vectors++; if (ack_cyc_q[i+1] - done_cyc_q[i] !== 2) begin miscompares++; $display("FAIL %s_gap[%0d]: got %0d expected 2", name, i, ack_cyc_q[i+1] - done_cyc_q[i]); end
            end
        end
    endtask

    task automatic test_contention();
        bit to;
        do_reset();
        data_r = {32'd30, 32'd20, 32'd10};
        conv_lat = $urandom_range(1, 8);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(2'(next_grant(3'b111, rr_last)));
            rr_last = next_grant(3'b111, rr_last);
        end
        run(3'b111, 1'b1, 4, 200, to);
        vectors++; if (to) begin miscompares++; $display("FAIL contention_timeout: got %0d dones expected 4", done_idx_q.size()); end
        check_sequence("contention", conv_lat);
        tick(2);
    endtask

    task automatic test_fairness();
        bit to;
        do_reset();
        data_r = {32'($urandom), 32'($urandom_range(0, 999)), 32'd5};
        conv_lat = $urandom_range(1, 6);
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(2'(next_grant(3'b110, rr_last)));
            rr_last = next_grant(3'b110, rr_last);
        end
        run(3'b110, 1'b1, 3, 200, to);
        vectors++; if (to) begin miscompares++; $display("FAIL fairness_timeout: got %0d dones expected 3", done_idx_q.size()); end
        check_sequence("fairness", conv_lat);
        tick(2);
    endtask

    task automatic test_timeout();
        bit to;
        data_r[0*DW +: DW] = 32'd4242;
        conv_hang = 1'b1;
        run(3'b001, 1'b0, 1, 200, to);
        conv_hang = 1'b0;
        vectors++; if (to) begin miscompares++; $display("FAIL timeout_nodone: got no done expected done_o[0]"); end
        else begin
            rr_last = 0;
            vectors++; if (done_cyc_q[0] - (ack_cyc_q[0] + 1) !== TO) begin miscompares++; $display("FAIL timeout_lat: got %0d expected %0d", done_cyc_q[0] - ack_cyc_q[0] - 1, TO); end
            vectors++; if (done_idx_q[0] !== 0) begin miscompares++; $display("FAIL timeout_idx: got %0d expected 0", done_idx_q[0]); end
            vectors++; if (done_err_q[0] !== 1'b1) begin miscompares++; $display("FAIL timeout_err: got %0d expected 1", done_err_q[0]); end
            vectors++; if (done_ascii_q[0] !== '0) begin miscompares++; $display("FAIL timeout_ascii: got %0h expected 0", done_ascii_q[0]); end
            vectors++; if (done_w_q[0] !== 4'd0) begin miscompares++; $display("FAIL timeout_width: got %0d expected 0", done_w_q[0]); end
        end
        tick(2);
        data_r[2*DW +: DW] = 32'($urandom_range(0, 255));
        conv_lat = 3;
        exp_q.delete();
        exp_q.push_back(2'd2);
        rr_last = 2;
        run(3'b100, 1'b0, 1, 40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL after_timeout_nodone: got no done expected done_o[2]"); end
        check_sequence("after_timeout", 3);
        tick(2);
    endtask

    task automatic test_bad_width();
        bit to;
        data_r[1*DW +: DW] = 32'd77;
        conv_bad = 1'b1;
        conv_lat = 2;
        run(3'b010, 1'b0, 1, 40, to);
        conv_bad = 1'b0;
        rr_last = 1;
        vectors++; if (to) begin miscompares++; $display("FAIL badw_nodone: got no done expected done_o[1]"); end
        else begin
            vectors++; if (done_idx_q[0] !== 1) begin miscompares++; $display("FAIL badw_idx: got %0d expected 1", done_idx_q[0]); end
            vectors++; if (done_err_q[0] !== 1'b1) begin miscompares++; $display("FAIL badw_err: got %0d expected 1", done_err_q[0]); end
            vectors++; if (done_w_q[0] !== 4'd11) begin miscompares++; $display("FAIL badw_width: got %0d expected 11", done_w_q[0]); end
        end
        tick(2);
    endtask

    task automatic test_reset_mid_wait();
        bit to;
        bit acked;
        int dones;
        int busy_seen;
        data_r[0*DW +: DW] = 32'd9999;
        conv_lat = 20;
        acked = 1'b0;
        req_r = 3'b001;
        for (int c = 0; c < 10 && !acked; c++) begin
            @(negedge clk);
            if (bus.ack_o[0]) begin acked = 1'b1; req_r = '0; end
        end
        req_r = '0;
        vectors++; if (!acked) begin miscompares++; $display("FAIL midrst_ack: got no ack expected ack_o[0]"); end
        tick(5);
        vectors++; if (bus.busy_o !== 1'b1) begin miscompares++; $display("FAIL midrst_busy_before: got %0d expected 1", bus.busy_o); end
        rst = 1'b0;
        tick(1);
        vectors++; if ({bus.ack_o, bus.done_o, bus.err_o, bus.busy_o, bus.conv_start_o} !== '0) begin miscompares++; $display("FAIL midrst_ctl: got %0h expected 0", {bus.ack_o, bus.done_o, bus.err_o, bus.busy_o, bus.conv_start_o}); end
        vectors++; if ({bus.ascii_o, bus.width_o, bus.conv_data_o} !== '0) begin miscompares++; $display("FAIL midrst_data: got %0h expected 0", {bus.ascii_o, bus.width_o, bus.conv_data_o}); end
        tick(1);
        rst = 1'b1;
        rr_last = NR - 1;
        tick(1);
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        dones = 0;
        busy_seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.done_o != '0) dones++;
            if (bus.busy_o) busy_seen++;
        end
        vectors++; if (dones !== 0) begin miscompares++; $display("FAIL midrst_stray_done: got %0d done pulses expected 0", dones); end
        vectors++; if (busy_seen !== 0) begin miscompares++; $display("FAIL midrst_stray_busy: got %0d busy cycles expected 0", busy_seen); end
        conv_lat = 4;
        exp_q.delete();
        exp_q.push_back(2'd0);
        rr_last = 0;
        run(3'b001, 1'b0, 1, 40, to);
        vectors++; if (to) begin miscompares++; $display("FAIL midrst_next_nodone: got no done expected done_o[0]"); end
        check_sequence("midrst_next", 4);
        tick(2);
    endtask

    task automatic test_random();
        bit to;
        logic [NR-1:0] mask;
        logic [NR-1:0] pend;
        int g;
        for (int r = 0; r < 25; r++) begin
            mask = NR'($urandom_range(1, 7));
            for (int k = 0; k < NR; k++) begin
                data_r[k*DW +: DW] = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 99)) : 32'($urandom);
            end
            conv_lat = $urandom_range(1, 10);
            exp_q.delete();
            pend = mask;
            while (pend != '0) begin
                g = next_grant(pend, rr_last);
                exp_q.push_back(2'(g));
                pend[g] = 1'b0;
                rr_last = g;
            end
            run(mask, 1'b0, exp_q.size(), 300, to);
            vectors++; if (to) begin miscompares++; $display("FAIL random_timeout[%0d]: got %0d dones expected %0d", r, done_idx_q.size(), exp_q.size()); end
            check_sequence("random", conv_lat);
            tick($urandom_range(2, 4));
            vectors++; if (bus.ascii_o !== ref_ascii(op(int'(exp_q[exp_q.size()-1])))) begin miscompares++; $display("FAIL random_hold[%0d]: got %0h expected %0h", r, bus.ascii_o, ref_ascii(op(int'(exp_q[exp_q.size()-1])))); end
        end
    endtask

    initial begin
        tick(2);
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_timeout();
        test_bad_width();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "time limit");
    end
endmodule
